// File: rtl/linsys_solve_ctrl.sv
// linsys_solve_ctrl: serial loader plus fraction-free Gaussian elimination
// controller that classifies a 3x3 linear system (unique / infinite / none).
// Optional build macro LINSYS_CYCCNT_EN adds the cyc_cnt busy-cycle counter port.
module linsys_solve_ctrl #(
  parameter int COEF_W = 3,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [COEF_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        rank_a,
  output logic [1:0]        rank_aug,
  output logic [1:0]        sol_class
`ifdef LINSYS_CYCCNT_EN
  ,
  output logic [3:0]        cyc_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PIVOT,
    S_ELIM,
    S_CLASSIFY
  } state_t;

  state_t state, state_nx;

  logic signed [ACC_W-1:0] m [0:2][0:3];
  logic [3:0] beat;
  logic [1:0] col, prow, erow, pivots;
  logic       accept, last_beat;
  logic       found, aug_nz;
  logic [1:0] fidx;
  logic signed [ACC_W-1:0] p, f;

  assign accept    = in_valid & in_ready;
  assign last_beat = accept && (beat == 4'd11);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    in_ready = 1'b1;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_LOAD;
      S_LOAD:  if (last_beat) state_nx = S_PIVOT;
      S_PIVOT: begin
        busy     = 1'b1;
        in_ready = 1'b0;
        if (found) state_nx = (prow == 2'd2) ? S_CLASSIFY : S_ELIM;
        else       state_nx = (col == 2'd2)  ? S_CLASSIFY : S_PIVOT;
      end
      S_ELIM: begin
        busy     = 1'b1;
        in_ready = 1'b0;
        if (erow == 2'd2)
          state_nx = (col == 2'd2 || prow == 2'd2) ? S_CLASSIFY : S_PIVOT;
      end
      S_CLASSIFY: begin
        busy     = 1'b1;
        in_ready = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pivot search over rows prow..2 and augmented-column test for rows >= pivots
  always_comb begin
    logic [1:0] ri;
    ri     = '0;
    found  = 1'b0;
    fidx   = prow;
    aug_nz = 1'b0;
    for (int unsigned r = 0; r < 3; r++) begin
      ri = 2'(r);
      if (!found && ri >= prow && m[ri][col] != '0) begin
        found = 1'b1;
        fidx  = ri;
      end
      if (ri >= pivots && m[ri][3] != '0) aug_nz = 1'b1;
    end
  end

  // Pivot and eliminated-row element selection for the shared row update
  always_comb begin
    p = m[prow][col];
    f = m[erow][col];
  end

  // Datapath: coefficient load, row swap, row update, classification
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned k = 0; k < 4; k++)
          m[r][k] <= '0;
      beat      <= '0;
      col       <= '0;
      prow      <= '0;
      erow      <= '0;
      pivots    <= '0;
      done      <= 1'b0;
      rank_a    <= '0;
      rank_aug  <= '0;
      sol_class <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            m[beat[3:2]][beat[1:0]] <= {{(ACC_W-COEF_W){1'b0}}, in_data};
            if (last_beat) begin
              beat   <= '0;
              col    <= '0;
              prow   <= '0;
              pivots <= '0;
            end else begin
              beat <= beat + 4'd1;
            end
          end
        end
        S_PIVOT: begin
          if (found) begin
            // fidx may equal prow; the two writes then store identical data
            for (int unsigned k = 0; k < 4; k++) begin
              m[prow][k] <= m[fidx][k];
              m[fidx][k] <= m[prow][k];
            end
            pivots <= pivots + 2'd1;
            erow   <= prow + 2'd1;
            if (prow == 2'd2) begin
              col  <= col + 2'd1;
              prow <= prow + 2'd1;
            end
          end else begin
            col <= col + 2'd1;
          end
        end
        S_ELIM: begin
          for (int unsigned k = 0; k < 4; k++)
            m[erow][k] <= p * m[erow][k] - f * m[prow][k];
          erow <= erow + 2'd1;
          if (erow == 2'd2) begin
            col  <= col + 2'd1;
            prow <= prow + 2'd1;
          end
        end
        S_CLASSIFY: begin
          rank_a   <= pivots;
          rank_aug <= pivots + {1'b0, aug_nz};
          if (aug_nz)               sol_class <= 2'b11;
          else if (pivots == 2'd3)  sol_class <= 2'b01;
          else                      sol_class <= 2'b10;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LINSYS_CYCCNT_EN
  // Busy-cycle counter, restarted by the final coefficient beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cyc_cnt <= '0;
    else if (last_beat) cyc_cnt <= '0;
    else if (busy)      cyc_cnt <= cyc_cnt + 4'd1;
  end
`endif

endmodule

// File: tb/tb_linsys_solve_ctrl.sv
// Self-checking bench for linsys_solve_ctrl: directed spec vectors plus
// randomized systems checked against a determinant/minor-based rank model.
module tb_linsys_solve_ctrl;
  localparam int COEF_W = 3;
  localparam int ACC_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [COEF_W-1:0] in_data = '0;
  logic in_ready, busy, done;
  logic [1:0] rank_a, rank_aug, sol_class;
  logic [3:0] cyc_seen = '0;
`ifdef LINSYS_CYCCNT_EN
  logic [3:0] cyc_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef int mat_t [3][4];
  typedef int vec_t [12];

  linsys_solve_ctrl #(.COEF_W(COEF_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done),
    .rank_a(rank_a), .rank_aug(rank_aug), .sol_class(sol_class)
`ifdef LINSYS_CYCCNT_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model (minors, not elimination) ----------------
  function automatic mat_t to_mat(input vec_t c);
    mat_t a;
    for (int i = 0; i < 12; i++) a[i/4][i%4] = c[i];
    return a;
  endfunction

  function automatic int det3(input mat_t a, input int c0, input int c1, input int c2);
    return a[0][c0]*(a[1][c1]*a[2][c2]-a[1][c2]*a[2][c1])
         - a[0][c1]*(a[1][c0]*a[2][c2]-a[1][c2]*a[2][c0])
         + a[0][c2]*(a[1][c0]*a[2][c1]-a[1][c1]*a[2][c0]);
  endfunction

  // rank of the submatrix made of the first nc columns
  function automatic int rank_of(input mat_t a, input int nc);
    for (int c0 = 0; c0 < nc; c0++)
      for (int c1 = c0+1; c1 < nc; c1++)
        for (int c2 = c1+1; c2 < nc; c2++)
          if (det3(a, c0, c1, c2) != 0) return 3;
    for (int r0 = 0; r0 < 3; r0++)
      for (int r1 = r0+1; r1 < 3; r1++)
        for (int c0 = 0; c0 < nc; c0++)
          for (int c1 = c0+1; c1 < nc; c1++)
            if (a[r0][c0]*a[r1][c1] - a[r0][c1]*a[r1][c0] != 0) return 2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < nc; c++)
        if (a[r][c] != 0) return 1;
    return 0;
  endfunction

  // edges from the 12th beat until done is seen: 1 + PIVOT/ELIM cycles
  function automatic int model_latency(input mat_t a);
    int cyc, prow;
    cyc = 0; prow = 0;
    for (int col = 0; col < 3; col++) begin
      cyc++;
      if (rank_of(a, col+1) > rank_of(a, col)) begin
        cyc += 2 - prow;
        prow++;
        if (prow == 3) break;
      end
    end
    return cyc + 1;
  endfunction

  function automatic logic [1:0] model_class(input int ra, input int rg);
    if (ra < rg)  return 2'b11;
    if (ra == 3)  return 2'b01;
    return 2'b10;
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  task automatic load_beats(input vec_t c, input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = COEF_W'(c[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, output int lat, output bit tmo);
    tmo = 1'b1; lat = 0;
    for (int k = start; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; tmo = 1'b0; break; end
    end
  endtask

  task automatic run_system(input vec_t c, input bit gaps, output int lat,
                            output logic [1:0] ra, output logic [1:0] rg,
                            output logic [1:0] sc, output logic done_next,
                            output bit tmo);
    load_beats(c, 12, gaps);
    wait_done(1, lat, tmo);
    ra = rank_a; rg = rank_aug; sc = sol_class;
`ifdef LINSYS_CYCCNT_EN
    cyc_seen = cyc_cnt;
`endif
    @(posedge clk); #1;
    done_next = done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (rank_a !== 2'd0 || rank_aug !== 2'd0) begin errors++; $display("FAIL reset_ranks got=%0d/%0d want=0/0", rank_a, rank_aug); end
    checks++; if (sol_class !== 2'b00) begin errors++; $display("FAIL reset_class got=%b want=00", sol_class); end
`ifdef LINSYS_CYCCNT_EN
    checks++; if (cyc_cnt !== 4'd0) begin errors++; $display("FAIL reset_cyc_cnt got=%0d want=0", cyc_cnt); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input string name, input vec_t c, input int exp_ra,
                               input int exp_rg, input logic [1:0] exp_sc, input int exp_lat);
    int lat; logic [1:0] ra, rg, sc; logic dn; bit tmo;
    run_system(c, 1'b0, lat, ra, rg, sc, dn, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL %s_timeout no done within 40 cycles", name); end
    checks++; if (ra !== 2'(exp_ra)) begin errors++; $display("FAIL %s_rank_a got=%0d want=%0d", name, ra, exp_ra); end
    checks++; if (rg !== 2'(exp_rg)) begin errors++; $display("FAIL %s_rank_aug got=%0d want=%0d", name, rg, exp_rg); end
    checks++; if (sc !== exp_sc) begin errors++; $display("FAIL %s_class got=%b want=%b", name, sc, exp_sc); end
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got=%b want=0", name, dn); end
    checks++; if (rank_a !== 2'(exp_ra) || sol_class !== exp_sc) begin errors++; $display("FAIL %s_hold got=%0d/%b want=%0d/%b", name, rank_a, sol_class, exp_ra, exp_sc); end
`ifdef LINSYS_CYCCNT_EN
    checks++; if (cyc_seen !== 4'(exp_lat)) begin errors++; $display("FAIL %s_cyc_cnt got=%0d want=%0d", name, cyc_seen, exp_lat); end
`endif
  endtask

  task automatic test_busy_handshake();
    vec_t c = '{3,0,3,0, 0,3,3,0, 3,3,0,1};
    int lat; bit tmo;
    load_beats(c, 12, 1'b0);
    in_valid = 1'b1; in_data = 3'd5;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready cyc=%0d got=%b want=0", k, in_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_flag cyc=%0d got=%b want=1", k, busy); end
    end
    in_valid = 1'b0;
    wait_done(4, lat, tmo);
    checks++; if (tmo || lat != 7) begin errors++; $display("FAIL busy_latency got=%0d timeout=%0d want=7", lat, tmo); end
    checks++; if (rank_a !== 2'd3 || rank_aug !== 2'd3 || sol_class !== 2'b01) begin errors++; $display("FAIL busy_result got=%0d/%0d/%b want=3/3/01", rank_a, rank_aug, sol_class); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_ops();
    vec_t c  = '{3,0,3,0, 0,3,3,0, 3,3,0,1};
    vec_t c2 = '{0,3,0,1, 3,0,0,2, 0,0,3,3};
    int lat; logic [1:0] ra, rg, sc; logic dn; bit tmo;
    load_beats(c, 12, 1'b0);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midelim_busy got=%b want=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL midelim_flags got busy=%b ready=%b done=%b want 0/1/0", busy, in_ready, done); end
    checks++; if (rank_a !== 2'd0 || rank_aug !== 2'd0 || sol_class !== 2'b00) begin errors++; $display("FAIL midelim_results got=%0d/%0d/%b want=0/0/00", rank_a, rank_aug, sol_class); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // partial load aborted by reset must be discarded
    load_beats(c, 5, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_system(c2, 1'b0, lat, ra, rg, sc, dn, tmo);
    checks++; if (tmo || lat != 7) begin errors++; $display("FAIL after_reset_latency got=%0d timeout=%0d want=7", lat, tmo); end
    checks++; if (ra !== 2'd3 || rg !== 2'd3 || sc !== 2'b01) begin errors++; $display("FAIL after_reset_result got=%0d/%0d/%b want=3/3/01", ra, rg, sc); end
  endtask

  task automatic test_random(input int n);
    vec_t c; mat_t a;
    int lat, era, erg, elat; logic [1:0] ra, rg, sc, esc; logic dn; bit tmo;
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < 12; i++)
        c[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        // duplicate a row's coefficients, optionally changing its constant
        int src; src = int'($urandom_range(0, 1));
        for (int k = 0; k < 3; k++) c[8+k] = c[4*src+k];
        if ($urandom_range(0, 1) == 0) c[11] = c[4*src+3];
      end
      a = to_mat(c);
      era = rank_of(a, 3); erg = rank_of(a, 4);
      esc = model_class(era, erg); elat = model_latency(a);
      run_system(c, 1'b1, lat, ra, rg, sc, dn, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL rand%0d_timeout", t); end
      checks++; if (ra !== 2'(era) || rg !== 2'(erg)) begin errors++; $display("FAIL rand%0d_ranks got=%0d/%0d want=%0d/%0d", t, ra, rg, era, erg); end
      checks++; if (sc !== esc) begin errors++; $display("FAIL rand%0d_class got=%b want=%b", t, sc, esc); end
      checks++; if (lat != elat) begin errors++; $display("FAIL rand%0d_latency got=%0d want=%0d", t, lat, elat); end
      checks++; if (dn !== 1'b0) begin errors++; $display("FAIL rand%0d_done_pulse got=%b want=0", t, dn); end
    end
  endtask

  initial begin
    vec_t v_uni  = '{3,0,3,0, 0,3,3,0, 3,3,0,1};
    vec_t v_none = '{3,0,3,0, 0,3,3,0, 0,0,0,1};
    vec_t v_inf  = '{3,0,3,0, 0,3,3,0, 0,0,0,0};
    vec_t v_swap = '{0,3,0,1, 3,0,0,2, 0,0,3,3};
    vec_t v_zero = '{0,0,0,0, 0,0,0,0, 0,0,0,0};
    vec_t v_max  = '{7,7,7,7, 7,7,7,7, 7,7,7,7};
    test_reset();
    test_directed("unique",   v_uni,  3, 3, 2'b01, 7);
    test_directed("nosol",    v_none, 2, 3, 2'b11, 7);
    test_directed("infinite", v_inf,  2, 2, 2'b10, model_latency(to_mat(v_inf)));
    test_directed("swap",     v_swap, 3, 3, 2'b01, 7);
    test_directed("zero",     v_zero, 0, 0, 2'b10, 4);
    test_directed("allmax",   v_max,  1, 1, 2'b10, model_latency(to_mat(v_max)));
    test_busy_handshake();
    test_reset_mid_ops();
    test_random(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/linsys_solve_ctrl.md
# linsys_solve_ctrl

- Sequential controller for the 3-equation, 3-unknown linear-system classifier.
- Accepts the 12 augmented-matrix coefficients serially over a valid/ready port.
- Runs column-wise integer Gaussian elimination one row update per cycle on a single shared row-update datapath.
- Reports the coefficient rank, the augmented rank and the solution class, then returns to idle for the next system.

## Interface
- COEF_W, 3: unsigned coefficient width.
- ACC_W, 16: signed internal row-element width. Must satisfy ACC_W ≥ 4*COEF_W+4.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  coefficient beat valid.
- in_data  in  COEF_W  coefficient, unsigned.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- busy  out  1  elimination or classification in progress.
- done  out  1  one-cycle pulse; results valid.
- rank_a  out  2  rank of the 3x3 coefficient matrix.
- rank_aug  out  2  rank of the 3x4 augmented matrix.
- sol_class  out  2  01 unique, 10 infinite, 11 none, 00 no result since reset.
- cyc_cnt  out  4  present only with LINSYS_CYCCNT_EN.

## Operation
- **Beat order:** row-major a1,b1,c1,d1,a2,b2,c2,d2,a3,b3,c3,d3. Each beat is zero-extended into a 3x4 register array of width ACC_W.
- **States:** IDLE, LOAD, PIVOT, ELIM, CLASSIFY.
- **IDLE:** in_ready=1. The first accepted beat moves to LOAD with beat count 1.
- **LOAD:** in_ready=1. The 12th accepted beat moves to PIVOT, with col=0 and prow=0.
- **PIVOT (1 cycle):**
  - Search rows prow..2 for the lowest-index nonzero entry in column col.
  - If found: swap it into row prow in the same cycle, pivots+1, erow=prow+1.
    - Go to ELIM if erow≤2.
    - Otherwise col+1, prow+1, and go to CLASSIFY if col or prow reaches 3, else PIVOT.
  - If not found: col+1, prow unchanged; go to CLASSIFY if col reaches 3, else PIVOT.
- **ELIM (1 cycle per row):**
  - row[erow][k] ← p*row[erow][k] − f*row[prow][k] for all 4 columns in parallel, where p=row[prow][col] and f=row[erow][col].
  - The update is executed even when f=0.
  - erow+1; after row 2, col+1 and prow+1, then go to PIVOT, or to CLASSIFY if col or prow reaches 3.
- **CLASSIFY (1 cycle):**
  - rank_a ← pivots.
  - rank_aug ← pivots+1 if any row ≥ pivots has a nonzero column-3 entry, else pivots.
  - sol_class ← 01 if both ranks are 3; 10 if the ranks are equal and less than 3; 11 if rank_a<rank_aug.
  - Go to IDLE with done=1 for that IDLE cycle.
- **Arithmetic:** signed ACC_W, two's complement, no saturation. The width rule guarantees no overflow for any COEF_W input.
- **Result hold:** results hold until the next CLASSIFY. A new load may begin in the done cycle.

## Timing
- **Reset values:** in_ready=1, busy=0, done=0, rank_a=0, rank_aug=0, sol_class=00, cyc_cnt=0. State is IDLE and the array and counters are cleared.
- **busy:** 1 in PIVOT, ELIM and CLASSIFY. in_ready=0 whenever busy=1, and in_valid is ignored then.
- **Latency:** if the 12th beat is accepted at edge T, done rises after edge T+1+N. N is the number of PIVOT and ELIM cycles.
  - Full rank: N=6, so done=1 after T+7.
  - All-zero matrix: N=3.
- **Load stall:** a gap in in_valid during LOAD just stalls; there is no timeout.
- **Async reset:** rst_n low at any point, including mid-LOAD or mid-ELIM, clears immediately to the reset values. Partial data is discarded.

## Configuration
- **LINSYS_CYCCNT_EN defined:**
  - cyc_cnt counts busy cycles of the current computation, cleared on the 12th beat.
  - It holds its value at done until the next 12th beat.
  - Full rank gives 7.
- **LINSYS_CYCCNT_EN undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Unique solution:** load 3,0,3,0, 0,3,3,0, 3,3,0,1 → rank_a=3, rank_aug=3, sol_class=01. done after T+7; the final row3 equals 0,0,−162,27.
- **No solution:** load 3,0,3,0, 0,3,3,0, 0,0,0,1 → rank_a=2, rank_aug=3, sol_class=11, done after T+7.
- **Infinite solutions:** load 3,0,3,0, 0,3,3,0, 0,0,0,0 → rank_a=2, rank_aug=2, sol_class=10.
- **Pivot swap:** load 0,3,0,1, 3,0,0,2, 0,0,3,3 → rows 1 and 2 swap in the first PIVOT cycle; result 3/3/01.
- **Zero and worst case:**
  - All twelve beats 0 → 0/0/10, done after T+4.
  - All twelve beats 7 → 1/1/10, with no overflow.
- **Handshake and reset:**
  - in_valid held high while busy → no beat accepted, in_ready=0.
  - rst_n pulsed low mid-ELIM → all outputs at reset values in the same cycle.
  - The next 12 beats then give a correct result.
